param_reg_file: RTL and testbench
=================================

# param_reg_file

Parametrised general-purpose register file for the ARM datapath: DEPTH registers of WIDTH bits, one write port and NUM_READ independent read ports. Generalises the single enabled 64-bit register into an addressed array with a hard-wired zero register, same-cycle write-to-read bypass and a 32-bit (W-register) write mode. It sits in the decode stage, feeding operand reads and accepting writeback.

## Interface
- WIDTH, 64, data width of each register; must be even and at least 8.
- DEPTH, 32, number of architectural registers; need not be a power of two.
- NUM_READ, 2, number of read ports, 1..4.
- ZERO_REG, 31, index that always reads 0 and ignores writes. Set to DEPTH or above to disable it.
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- write_enable  in  1  commit wr_data to wr_addr at the next rising edge.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  WIDTH  write data.
- wr_half  in  1  0 = full-width write; 1 = low WIDTH/2 bits written, upper half zeroed (ARM W-register semantics).
- rd_addr  in  NUM_READ x ADDR_W  read address per port.
- rd_data  out  NUM_READ x WIDTH  read data per port; combinational.

## Operation
- Storage: DEPTH words, every word cleared to 0 by reset.
- Write: on a rising edge with write_enable=1, reset=0, wr_addr<DEPTH and wr_addr!=ZERO_REG, the word takes its effective write value:
  - wr_half=0: wr_data.
  - wr_half=1: {WIDTH/2 zeros, wr_data[WIDTH/2-1:0]}.
- Ignored writes: write_enable=0, wr_addr=ZERO_REG or wr_addr>=DEPTH leave all words unchanged.
- Read, per port p, in priority order:
  - rd_addr[p]=ZERO_REG or rd_addr[p]>=DEPTH: 0.
  - reset=1: 0.
  - write_enable=1 and wr_addr=rd_addr[p]: the effective write value (bypass).
  - Otherwise: the stored word.
- Ports are fully independent. Any number of ports may share an address and all receive identical data.

## Timing
- Reset: asynchronous assertion clears all words immediately. Every rd_data reads 0 while reset is high and until the first committed write.
- Reset deassertion: the first rising edge with reset=0 may commit a write.
- Write latency to storage: one edge. Read latency: combinational, zero cycles.
- Bypass: a read of the address being written returns the new value in the same cycle, before the edge. After the edge, the stored value is identical. A read-after-write hazard therefore needs no stall.
- Reset during a write cycle: the write is discarded and the word stays 0 after reset releases.
- Back-to-back writes to one address: the last edge wins. Each intermediate value is visible through bypass only during its own cycle.
- No X on any rd_data after reset for any address input in 0..2^ADDR_W-1.

## Structure
- Package param_reg_file_pkg: default WIDTH/DEPTH/NUM_READ/ZERO_REG constants, and a function computing the effective write value from wr_data and wr_half.
- Sub-module param_register:
  - One WIDTH-bit register with enable and async active-high reset, built from the existing D_FF_EN cells.
  - Instantiated DEPTH times by generate, skipping ZERO_REG.
  - Enable is a decoded write_enable for its index.
- Read-side muxing (decode, zero, bypass) is done in the top module, with one generate iteration per port.

## Test plan
- Reset: assert reset with random contents stored, then read all 32 addresses on both ports -> every rd_data=0, including while reset is held.
- Write/read: write 0xDEAD_BEEF_0123_4567 to X5, then read X5 on the next cycle -> 0xDEAD_BEEF_0123_4567. X4 and X6 are unchanged at 0.
- Bypass: in one cycle set write_enable=1, wr_addr=7, wr_data=0x1111, rd_addr[0]=7, rd_addr[1]=8 -> rd_data[0]=0x1111 before the edge, rd_data[1]=0. After the edge, X7 reads 0x1111.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to X31, with both ports reading 31 in the same and the next cycle -> always 0. Other registers are unchanged.
- Half write: X3 holds 0xAAAA_AAAA_AAAA_AAAA; write wr_half=1 with wr_data=0x5555_5555_1234_5678 -> bypass and stored value both equal 0x0000_0000_1234_5678.
- Reset mid-write: assert reset asynchronously in the cycle X9 is being written with 0x42, then release it -> X9 reads 0 and no other word changes. Also repeat with parameters WIDTH=32, DEPTH=12, NUM_READ=3: writes to address 13 are ignored and reads of address 13 return 0.

Source files
------------

// File: rtl/param_reg_file_pkg.sv
// Shared defaults and write-value shaping for the
// general-purpose register file.
package param_reg_file_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_READ = 2;
  localparam int DEF_ZERO_REG = 31;
  localparam int MAX_W        = 256;

  // W-register writes keep the low half and zero the rest
  function automatic logic [MAX_W-1:0] eff_wdata(
    input logic [MAX_W-1:0] d,
    input logic             half,
    input int               w
  );
    logic [MAX_W-1:0] r;
    int               lim;
    r   = '0;
    lim = half ? (w / 2) : w;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < lim) r[i] = d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/param_reg_file_param_register.sv
// One WIDTH-bit storage word with write enable and
// asynchronous active-high clear.
module param_register #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Register file: DEPTH words, one write port, NUM_READ
// combinational read ports with zero register and bypass.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NUM_READ = DEF_NUM_READ,
  parameter  int ZERO_REG = DEF_ZERO_REG,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               write_enable,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [WIDTH-1:0]                   wr_data,
  input  logic                               wr_half,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]    rd_addr,
  output logic [NUM_READ-1:0][WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] wval;
  logic [WIDTH-1:0] q [DEPTH];

  assign wval = WIDTH'(eff_wdata(MAX_W'(wr_data), wr_half, WIDTH));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (i == ZERO_REG) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = write_enable && (wr_addr == ADDR_W'(i));
      param_register #(
        .WIDTH(WIDTH)
      ) u_reg (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .d    (wval),
        .q    (q[i])
      );
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [31:0] a;
    logic        zero;
    logic        byp;
    assign a    = 32'(rd_addr[p]);
    // out-of-range addresses never index storage
    assign zero = (a >= DEPTH) || (a == ZERO_REG) || reset;
    assign byp  = write_enable && (wr_addr == rd_addr[p]);
    assign rd_data[p] = zero ? '0 :
                        byp  ? wval : q[rd_addr[p]];
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: default 64x32x2 instance and a
// 32-bit, 12-word, 3-port instance with zero register disabled.
module tb_param_reg_file;

  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic             a_we = 0;
  logic [4:0]       a_wa = 0;
  logic [63:0]      a_wd = 0;
  logic             a_half = 0;
  logic [1:0][4:0]  a_ra = '0;
  logic [1:0][63:0] a_rd;

  logic             b_we = 0;
  logic [3:0]       b_wa = 0;
  logic [31:0]      b_wd = 0;
  logic             b_half = 0;
  logic [2:0][3:0]  b_ra = '0;
  logic [2:0][31:0] b_rd;

  param_reg_file u_a (
    .clk(clk), .reset(reset), .write_enable(a_we),
    .wr_addr(a_wa), .wr_data(a_wd), .wr_half(a_half),
    .rd_addr(a_ra), .rd_data(a_rd)
  );

  param_reg_file #(
    .WIDTH(32), .DEPTH(12), .NUM_READ(3), .ZERO_REG(31)
  ) u_b (
    .clk(clk), .reset(reset), .write_enable(b_we),
    .wr_addr(b_wa), .wr_data(b_wd), .wr_half(b_half),
    .rd_addr(b_ra), .rd_data(b_rd)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // architectural model: plain arrays updated by the write rule
  logic [63:0] ma [32];
  logic [31:0] mb [12];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ma[i] <= '0;
      for (int i = 0; i < 12; i++) mb[i] <= '0;
    end else begin
      if (a_we && a_wa != 5'd31)
        ma[a_wa] <= a_half ? {32'h0, a_wd[31:0]} : a_wd;
      if (b_we && b_wa < 4'd12)
        mb[b_wa] <= b_half ? {16'h0, b_wd[15:0]} : b_wd;
    end
  end

  function automatic logic [63:0] exp_a(logic [4:0] ra);
    if (ra == 5'd31) return '0;
    if (reset) return '0;
    if (a_we && a_wa == ra)
      return a_half ? {32'h0, a_wd[31:0]} : a_wd;
    return ma[ra];
  endfunction

  function automatic logic [63:0] exp_b(logic [3:0] ra);
    if (ra >= 4'd12) return '0;
    if (reset) return '0;
    if (b_we && b_wa == ra)
      return {32'h0, b_half ? {16'h0, b_wd[15:0]} : b_wd};
    return {32'h0, mb[ra]};
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      check("cmp_a", a_rd[p], exp_a(a_ra[p]));
    for (int p = 0; p < 3; p++)
      check("cmp_b", {32'h0, b_rd[p]}, exp_b(b_ra[p]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1;
    repeat (2) tick();
    a_ra[0] = 5'd5;
    #1 check("reset_init", a_rd[0], 64'h0);
    reset = 0;

    // fill with random contents
    for (int i = 0; i < 32; i++) begin
      a_we = 1; a_wa = 5'(i); a_wd = {$urandom, $urandom};
      if (i < 12) begin
        b_we = 1; b_wa = 4'(i); b_wd = $urandom;
      end else begin
        b_we = 0;
      end
      tick();
    end
    a_we = 0; b_we = 0;
    tick();

    // reset held: every address reads zero
    reset = 1;
    #1 check("reset_held", a_rd[0], 64'h0);
    for (int i = 0; i < 32; i++) begin
      a_ra[0] = 5'(i); a_ra[1] = 5'(31 - i);
      b_ra[0] = 4'(i % 16); b_ra[1] = 4'((i + 5) % 16);
      tick();
    end
    reset = 0;
    a_ra[0] = 5'd5;
    tick();
    check("reset_after", a_rd[0], 64'h0);

    // write then read
    a_we = 1; a_wa = 5'd5; a_wd = 64'hDEAD_BEEF_0123_4567;
    tick();
    a_we = 0; a_ra[0] = 5'd5; a_ra[1] = 5'd4;
    #1 check("wr_x5", a_rd[0], 64'hDEAD_BEEF_0123_4567);
    check("wr_x4", a_rd[1], 64'h0);
    a_ra[1] = 5'd6;
    #1 check("wr_x6", a_rd[1], 64'h0);
    tick();

    // bypass
    a_we = 1; a_wa = 5'd7; a_wd = 64'h1111;
    a_ra[0] = 5'd7; a_ra[1] = 5'd8;
    #1 check("byp_x7", a_rd[0], 64'h1111);
    check("byp_x8", a_rd[1], 64'h0);
    tick();
    a_we = 0;
    #1 check("byp_store", a_rd[0], 64'h1111);
    tick();

    // zero register
    a_we = 1; a_wa = 5'd31; a_wd = '1;
    a_ra[0] = 5'd31; a_ra[1] = 5'd31;
    #1 check("zr_same", a_rd[0], 64'h0);
    check("zr_same1", a_rd[1], 64'h0);
    tick();
    a_we = 0;
    #1 check("zr_next", a_rd[1], 64'h0);
    a_ra[0] = 5'd5;
    #1 check("zr_other", a_rd[0], 64'hDEAD_BEEF_0123_4567);
    tick();

    // half write
    a_we = 1; a_wa = 5'd3; a_wd = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    a_half = 1; a_wd = 64'h5555_5555_1234_5678; a_ra[0] = 5'd3;
    #1 check("half_byp", a_rd[0], 64'h0000_0000_1234_5678);
    tick();
    a_we = 0; a_half = 0;
    #1 check("half_store", a_rd[0], 64'h0000_0000_1234_5678);
    tick();

    // back-to-back writes, last edge wins
    a_we = 1; a_wa = 5'd10; a_wd = 64'h1; a_ra[0] = 5'd10;
    tick();
    a_wd = 64'h2;
    #1 check("b2b_byp", a_rd[0], 64'h2);
    tick();
    a_we = 0;
    #1 check("b2b_last", a_rd[0], 64'h2);
    tick();

    // reset during a write
    a_we = 1; a_wa = 5'd9; a_wd = 64'h42; a_ra[0] = 5'd9;
    #1 check("mw_byp", a_rd[0], 64'h42);
    #1 reset = 1;
    #1 check("mw_rst", a_rd[0], 64'h0);
    tick();
    reset = 0; a_we = 0;
    #1 check("mw_x9", a_rd[0], 64'h0);
    tick();

    // narrow instance: out-of-range address, half write
    b_we = 1; b_wa = 4'd13; b_wd = 32'hFFFF_FFFF;
    b_ra[0] = 4'd13; b_ra[1] = 4'd2; b_ra[2] = 4'd11;
    #1 check("b_oor_byp", {32'h0, b_rd[0]}, 64'h0);
    tick();
    b_wa = 4'd2; b_wd = 32'hCAFE_BABE; b_half = 1;
    #1 check("b_half_byp", {32'h0, b_rd[1]}, 64'h0000_BABE);
    tick();
    b_wa = 4'd11; b_wd = 32'h1234_5678; b_half = 0;
    b_ra[2] = 4'd11;
    #1 check("b_x11_byp", {32'h0, b_rd[2]}, 64'h1234_5678);
    tick();
    b_we = 0;
    #1 check("b_oor", {32'h0, b_rd[0]}, 64'h0);
    check("b_half", {32'h0, b_rd[1]}, 64'h0000_BABE);
    check("b_x11", {32'h0, b_rd[2]}, 64'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      b_ra[0] = 4'(i); b_ra[1] = 4'(i); b_ra[2] = 4'(15 - i);
      tick();
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
